// File: rtl/multi_event_counter_pkg.sv
// Shared mode constants and helpers for the multi-channel event counter.
// Imported by the per-channel counter and by the top level.
package multi_event_counter_pkg;

    localparam int unsigned MODE_LEVEL = 0;
    localparam int unsigned MODE_EDGE  = 1;
    localparam int unsigned MODE_WRAP  = 0;
    localparam int unsigned MODE_SAT   = 1;

    // Read-select width; a single channel still needs a 1-bit select port.
    function automatic int unsigned sel_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/event_counter_ch.sv
// One counter channel: optional edge detect, count register, sticky overflow
// and a threshold compare on the live count.
module event_counter_ch
    import multi_event_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EDGE_MODE = MODE_LEVEL,
    parameter int unsigned SAT_MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_evt,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_thresh,
    output logic [WIDTH-1:0] o_count,
    output logic             o_ovf,
    output logic             o_thresh_hit
);

    logic             r_evt_d;
    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             w_inc;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;

    // Edge history tracks evt regardless of en, so raising en on a held
    // event never looks like an edge.
    always_comb begin
        if (EDGE_MODE == MODE_EDGE) begin
            w_inc = i_en & i_evt & ~r_evt_d;
        end else begin
            w_inc = i_en & i_evt;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (i_clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_inc) begin
            if (!(&r_count)) begin
                w_count_nxt = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                w_ovf_nxt = 1'b1;
                if (SAT_MODE == MODE_WRAP) begin
                    w_count_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_evt_d <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_evt_d <= i_evt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_count      = r_count;
    assign o_ovf        = r_ovf;
    assign o_thresh_hit = (r_count >= i_thresh);

endmodule

// File: rtl/multi_event_counter.sv
// N_CH independent event counters with a coherent snapshot bank and a
// registered, channel-muxed read port.
module multi_event_counter
    import multi_event_counter_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EDGE_MODE = MODE_LEVEL,
    parameter int unsigned SAT_MODE  = MODE_WRAP,
    localparam int unsigned SEL_W    = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  evt_in,
    input  logic             en,
    input  logic [N_CH-1:0]  clr,
    input  logic [WIDTH-1:0] thresh,
    input  logic             snap,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] count_out,
    output logic [N_CH-1:0]  ovf_out,
    output logic [N_CH-1:0]  thresh_hit
);

    logic [WIDTH-1:0] w_count  [N_CH];
    logic [WIDTH-1:0] r_shadow [N_CH];
    logic [WIDTH-1:0] w_rd_data;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        event_counter_ch #(
            .WIDTH     (WIDTH),
            .EDGE_MODE (EDGE_MODE),
            .SAT_MODE  (SAT_MODE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_evt        (evt_in[g]),
            .i_en         (en),
            .i_clr        (clr[g]),
            .i_thresh     (thresh),
            .o_count      (w_count[g]),
            .o_ovf        (ovf_out[g]),
            .o_thresh_hit (thresh_hit[g])
        );
    end

    // Shadow captures the pre-update live counts, so snap+clr keeps the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (snap) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_shadow[i] <= w_count[i];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (32'(rd_sel) < N_CH) begin
            w_rd_data = r_shadow[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_out <= '0;
        end else begin
            count_out <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_multi_event_counter.sv
// Self-checking bench: five configurations share one stimulus stream.
module tb_multi_event_counter;

    logic        clk;
    logic        rst;
    logic [3:0]  evt_in;
    logic        en;
    logic [3:0]  clr;
    logic [15:0] thresh;
    logic        snap;
    logic [1:0]  rd_sel;

    logic [15:0] co_a, co_b, co_e;
    logic [3:0]  co_c, co_d;
    logic [3:0]  ov_a, ov_b, ov_c, ov_d, th_a, th_b, th_c, th_d;
    logic [2:0]  ov_e, th_e;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  sel;
        int unsigned a, b, c, d, e;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [3:0]  evt;
        logic [3:0]  clr;
        int          n;
        int unsigned a, b, c, d;
        logic [3:0]  ovf;
    } vec_t;
    vec_t vecs[5];

    // A: level/wrap, B: edge/wrap, C: 4-bit wrap, D: 4-bit saturate, E: 3 channels.
    multi_event_counter #(.N_CH(4), .WIDTH(16), .EDGE_MODE(0), .SAT_MODE(0)) u_a (
        .clk(clk), .rst(rst), .evt_in(evt_in), .en(en), .clr(clr), .thresh(thresh),
        .snap(snap), .rd_sel(rd_sel), .count_out(co_a), .ovf_out(ov_a), .thresh_hit(th_a));
    multi_event_counter #(.N_CH(4), .WIDTH(16), .EDGE_MODE(1), .SAT_MODE(0)) u_b (
        .clk(clk), .rst(rst), .evt_in(evt_in), .en(en), .clr(clr), .thresh(thresh),
        .snap(snap), .rd_sel(rd_sel), .count_out(co_b), .ovf_out(ov_b), .thresh_hit(th_b));
    multi_event_counter #(.N_CH(4), .WIDTH(4), .EDGE_MODE(0), .SAT_MODE(0)) u_c (
        .clk(clk), .rst(rst), .evt_in(evt_in), .en(en), .clr(clr), .thresh(thresh[3:0]),
        .snap(snap), .rd_sel(rd_sel), .count_out(co_c), .ovf_out(ov_c), .thresh_hit(th_c));
    multi_event_counter #(.N_CH(4), .WIDTH(4), .EDGE_MODE(0), .SAT_MODE(1)) u_d (
        .clk(clk), .rst(rst), .evt_in(evt_in), .en(en), .clr(clr), .thresh(thresh[3:0]),
        .snap(snap), .rd_sel(rd_sel), .count_out(co_d), .ovf_out(ov_d), .thresh_hit(th_d));
    multi_event_counter #(.N_CH(3), .WIDTH(16), .EDGE_MODE(0), .SAT_MODE(0)) u_e (
        .clk(clk), .rst(rst), .evt_in(evt_in[2:0]), .en(en), .clr(clr[2:0]),
        .thresh(thresh), .snap(snap), .rd_sel(rd_sel), .count_out(co_e), .ovf_out(ov_e),
        .thresh_hit(th_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_snap();
        evt_in = 4'b0;
        clr    = 4'b0;
        snap   = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    // Expected readout queued when rd_sel is driven, checked one edge later.
    task automatic read_ch(input logic [1:0] sel, input int unsigned a, input int unsigned b,
                           input int unsigned c, input int unsigned d);
        sb_t s;
        rd_sel = sel;
        s.sel  = sel;
        s.a    = a;
        s.b    = b;
        s.c    = c;
        s.d    = d;
        s.e    = (sel < 2'd3) ? a : 0;
        sb_q.push_back(s);
        tick();
        s = sb_q.pop_front();
        chk($sformatf("cnt_a sel%0d", s.sel), 32'(co_a), s.a);
        chk($sformatf("cnt_b sel%0d", s.sel), 32'(co_b), s.b);
        chk($sformatf("cnt_c sel%0d", s.sel), 32'(co_c), s.c);
        chk($sformatf("cnt_d sel%0d", s.sel), 32'(co_d), s.d);
        chk($sformatf("cnt_e sel%0d", s.sel), 32'(co_e), s.e);
    endtask

    initial begin
        rst = 1'b0; evt_in = '0; en = 1'b0; clr = '0; thresh = 16'd0; snap = 1'b0;
        rd_sel = '0;

        vecs[0] = '{evt: 4'b0100, clr: 4'b0000, n: 7,  a: 7,  b: 1, c: 7, d: 7,  ovf: 4'b0000};
        vecs[1] = '{evt: 4'b0100, clr: 4'b0100, n: 1,  a: 0,  b: 0, c: 0, d: 0,  ovf: 4'b0000};
        vecs[2] = '{evt: 4'b0100, clr: 4'b0000, n: 1,  a: 1,  b: 1, c: 1, d: 1,  ovf: 4'b0000};
        vecs[3] = '{evt: 4'b0100, clr: 4'b0000, n: 20, a: 21, b: 2, c: 5, d: 15, ovf: 4'b0100};
        vecs[4] = '{evt: 4'b0000, clr: 4'b0100, n: 1,  a: 0,  b: 0, c: 0, d: 0,  ovf: 4'b0000};

        // Reset state
        do_reset();
        chk("reset count_out", {co_a, co_b, co_c, co_d, co_e}, 0);
        chk("reset ovf", 32'({ov_a, ov_b, ov_c, ov_d, ov_e}), 0);
        chk("thresh0 hit", 32'({th_a, th_b, th_c, th_d, th_e}), 32'h7FFFF);
        thresh = 16'd5;
        #1;
        chk("thresh5 hit", 32'({th_a, th_b, th_c, th_d, th_e}), 0);

        // Level counting, 20 cycles on channel 0
        en = 1'b1;
        evt_in = 4'b0001;
        repeat (20) tick();
        do_snap();
        read_ch(2'd0, 20, 1, 4, 15);
        read_ch(2'd1, 0, 0, 0, 0);
        read_ch(2'd2, 0, 0, 0, 0);
        read_ch(2'd3, 0, 0, 0, 0);
        chk("lvl ovf_a", 32'(ov_a), 0);
        chk("lvl ovf_c", 32'(ov_c), 32'b0001);
        chk("lvl ovf_d", 32'(ov_d), 32'b0001);

        // Edge mode: en raised on a held event, then pulses of 1, 2 and 5 cycles
        do_reset();
        en = 1'b0;
        evt_in = 4'b0010;
        repeat (2) tick();
        en = 1'b1;
        repeat (2) tick();
        evt_in = 4'b0000; repeat (2) tick();
        evt_in = 4'b0010; repeat (1) tick();
        evt_in = 4'b0000; repeat (2) tick();
        evt_in = 4'b0010; repeat (2) tick();
        evt_in = 4'b0000; repeat (2) tick();
        evt_in = 4'b0010; repeat (5) tick();
        evt_in = 4'b0000; repeat (2) tick();
        do_snap();
        read_ch(2'd1, 10, 3, 10, 10);
        read_ch(2'd0, 0, 0, 0, 0);

        // Wrap vs saturate: 17 increments
        do_reset();
        evt_in = 4'b0001;
        repeat (17) tick();
        do_snap();
        read_ch(2'd0, 17, 1, 1, 15);
        chk("wrap ovf_c", 32'(ov_c), 32'b0001);
        chk("sat ovf_d", 32'(ov_d), 32'b0001);
        chk("wrap ovf_b", 32'(ov_b), 0);

        // Clear priority and overflow clearing, table driven on channel 2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            evt_in = vecs[i].evt;
            clr    = vecs[i].clr;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d ovf_c", i), 32'(ov_c), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d ovf_d", i), 32'(ov_d), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d ovf_a", i), 32'(ov_a), 0);
            do_snap();
            read_ch(2'd2, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
        end

        // Threshold rises the cycle count reaches 5; shadow holds until next snap
        do_reset();
        evt_in = 4'b1000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("th_a[3] k%0d", k), 32'(th_a[3]), 32'(k >= 5));
            chk($sformatf("th_c[3] k%0d", k), 32'(th_c[3]), 32'(k >= 5));
        end
        do_snap();
        evt_in = 4'b1000;
        repeat (3) read_ch(2'd3, 5, 1, 5, 5);
        do_snap();
        read_ch(2'd3, 8, 2, 8, 8);

        // Mid-operation reset with counts and overflow live
        evt_in = 4'b0001;
        repeat (17) tick();
        chk("pre-rst ovf_c", 32'(ov_c), 32'b0001);
        do_snap();
        read_ch(2'd0, 17, 1, 1, 15);
        read_ch(2'd3, 8, 2, 8, 8);
        rst = 1'b0; evt_in = 4'b0001; snap = 1'b1;
        tick();
        rst = 1'b1; snap = 1'b0; evt_in = 4'b0000;
        chk("midrst count_out", {co_a, co_b, co_c, co_d, co_e}, 0);
        chk("midrst ovf", 32'({ov_a, ov_b, ov_c, ov_d, ov_e}), 0);
        chk("midrst thresh_hit", 32'({th_a, th_b, th_c, th_d, th_e}), 0);
        evt_in = 4'b0001;
        repeat (3) tick();
        do_snap();
        read_ch(2'd0, 3, 1, 3, 3);
        read_ch(2'd3, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
